// File: rtl/pll_reset_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and the
// width of the lock-loss event counter.
package pll_reset_seq_pkg;

  localparam int RELOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STDY_CLR,
    HOLD,
    RUN,
    LOST
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; both stages clear to 0 on async reset.
module sync_2ff (
  input  logic clock_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic [1:0] sync_q;

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_in};
    end
  end

  assign q_out = sync_q[1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer for the PLL clock domain: releases sys_rst_n_out after a stable
// lock hold time. Lock-loss statistics are built only with PLL_RST_SEQ_STATS_EN.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 1024,
  parameter int STDY_RST_CYCLES = 4
) (
  input  logic                    clock_in,
  input  logic                    rst_n_in,
  input  logic                    pll_locked_in,
  input  logic                    pll_locked_stdy_in,
  output logic                    pll_stdy_rst_out,
  output logic                    sys_rst_n_out,
  output logic                    ready_out,
  output logic                    lock_lost_out,
  output logic [RELOCK_CNT_W-1:0] relock_count_out
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int STDY_W = $clog2(STDY_RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STDY_W-1:0] STDY_LAST = STDY_W'(STDY_RST_CYCLES - 1);

  logic lock_s;
  logic stdy_s;

  sync_2ff u_sync_lock (
    .clock_in (clock_in),
    .rst_n_in (rst_n_in),
    .d_in     (pll_locked_in),
    .q_out    (lock_s)
  );

  sync_2ff u_sync_stdy (
    .clock_in (clock_in),
    .rst_n_in (rst_n_in),
    .d_in     (pll_locked_stdy_in),
    .q_out    (stdy_s)
  );

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STDY_W-1:0] stdy_cnt_q, stdy_cnt_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              ready_q, ready_d;
  logic              stdy_rst_q, stdy_rst_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    stdy_cnt_d = '0;
    case (state_q)
      RESET:     state_d = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_d = STDY_CLR;
      // Lock status is deliberately ignored while the sticky bit is being cleared.
      STDY_CLR: begin
        if (stdy_cnt_q == STDY_LAST) state_d = HOLD;
        else                         stdy_cnt_d = stdy_cnt_q + STDY_W'(1);
      end
      HOLD: begin
        if (!lock_s)                      state_d = WAIT_LOCK;
        else if (!stdy_s)                 hold_cnt_d = '0;
        else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      RUN:     if (!lock_s || !stdy_s) state_d = LOST;
      LOST:    state_d = WAIT_LOCK;
      default: state_d = RESET;
    endcase
    // Moore outputs are decoded from the next state so they register on the same edge.
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    stdy_rst_d  = (state_d == STDY_CLR);
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= RESET;
      hold_cnt_q  <= '0;
      stdy_cnt_q  <= '0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      stdy_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stdy_cnt_q  <= stdy_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      stdy_rst_q  <= stdy_rst_d;
    end
  end

  assign sys_rst_n_out    = sys_rst_n_q;
  assign ready_out        = ready_q;
  assign pll_stdy_rst_out = stdy_rst_q;

`ifdef PLL_RST_SEQ_STATS_EN
  logic                    lock_lost_q;
  logic [RELOCK_CNT_W-1:0] relock_cnt_q;

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lock_lost_q  <= 1'b0;
      relock_cnt_q <= '0;
    end else begin
      lock_lost_q <= (state_d == LOST);
      if (state_d == LOST && relock_cnt_q != '1) begin
        relock_cnt_q <= relock_cnt_q + RELOCK_CNT_W'(1);
      end
    end
  end

  assign lock_lost_out    = lock_lost_q;
  assign relock_count_out = relock_cnt_q;
`else
  assign lock_lost_out    = 1'b0;
  assign relock_count_out = '0;
`endif

endmodule
